// File: rtl/led_arb_pkg.sv
// Shared definitions for the LED time-slot arbiter.
//   - state_e       : arbiter FSM encoding (IDLE=0, SHOW=1)
//   - NUM_REQ/LED_W : requester count and LED width
//   - rr_onehot     : rotating-priority one-hot pick from (req, ptr)
//   - onehot_to_idx : index of the set bit of a one-hot vector
package led_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int LED_W   = 4;
  localparam int PTR_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

  // First requester with its bit set, searching ptr, ptr+1, ... modulo NUM_REQ.
  function automatic logic [NUM_REQ-1:0] rr_onehot(input logic [NUM_REQ-1:0] req,
                                                   input logic [PTR_W-1:0]   ptr);
    logic [NUM_REQ-1:0] oh;
    logic [PTR_W-1:0]   idx;
    logic               found;
    oh    = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + PTR_W'(k);
      if (req[idx] && !found) begin
        oh[idx] = 1'b1;
        found   = 1'b1;
      end
    end
    return oh;
  endfunction

  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (oh[k]) idx = PTR_W'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/m_led_arbiter_if.sv
// Bundle between application requesters and the arbiter.
//   w_req       : request per requester (bit i = requester i)
//   w_pat       : 4-bit pattern per requester, [4i+3:4i] = requester i
//   w_led       : registered LED drive
//   w_grant     : registered one-hot grant, zero when idle
//   w_busy      : registered, high while a slot is active
//   w_dbg_state : current arbiter FSM state, for checkers
// Handshake: a requester holds w_req[i] high for as long as it wants the
// LEDs; the grant is visible on w_grant one edge later, and dropping
// w_req[i] while granted ends the slot at the next edge.
interface m_led_arbiter_if;
  import led_arb_pkg::*;

  logic [NUM_REQ-1:0]       w_req;
  logic [NUM_REQ*LED_W-1:0] w_pat;
  logic [LED_W-1:0]         w_led;
  logic [NUM_REQ-1:0]       w_grant;
  logic                     w_busy;
  state_e                   w_dbg_state;

  modport master (
    output w_req, w_pat,
    input  w_led, w_grant, w_busy, w_dbg_state
  );

  modport slave (
    input  w_req, w_pat,
    output w_led, w_grant, w_busy, w_dbg_state
  );

endinterface

// File: rtl/m_tick_gen.sv
// Free-running divide-by-TICK_CNT tick generator (also used by the board
// blinker top).
//   w_clk   : clock
//   w_rst_n : asynchronous active-low reset
//   w_clr   : forces the count back to 0 at the next edge
//   w_tick  : high for the one cycle where the count equals TICK_CNT-1
module m_tick_gen #(
  parameter int TICK_CNT = 100000000
) (
  input  logic w_clk,
  input  logic w_rst_n,
  input  logic w_clr,
  output logic w_tick
);

  localparam int CW = $clog2(TICK_CNT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    w_tick = (cnt_q == CW'(TICK_CNT - 1));
    cnt_d  = cnt_q + CW'(1);
    if (w_tick || w_clr) cnt_d = '0;
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/m_led_arbiter.sv
// Round-robin time-slot scheduler for the 4 board LEDs.
// Each grant owns the LEDs for SLOT_TICKS ticks of TICK_CNT cycles; an idle
// arbiter shows a heartbeat toggling every tick.
//   w_clk   : clock
//   w_rst_n : asynchronous active-low reset
//   bus     : m_led_arbiter_if.slave (w_req, w_pat in; w_led, w_grant,
//             w_busy, w_dbg_state out)
// Optional build macro LED_ARB_BLINK_EN: the granted pattern is gated by a
// phase bit that starts at 1 on every grant and toggles each tick.
module m_led_arbiter
  import led_arb_pkg::*;
#(
  parameter int TICK_CNT   = 100000000,
  parameter int SLOT_TICKS = 2
) (
  input  logic            w_clk,
  input  logic            w_rst_n,
  m_led_arbiter_if.slave  bus
);

  localparam int SW = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;

  state_e             state_q, state_d;
  logic [SW-1:0]      slot_q, slot_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   gidx_q, gidx_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic               hb_q, hb_d;
`ifdef LED_ARB_BLINK_EN
  logic               ph_q, ph_d;
`endif

  logic               tick;
  logic               cnt_clr;
  logic               do_grant;
  logic               slot_end;
  logic [NUM_REQ-1:0] sel_oh;
  logic [PTR_W-1:0]   sel_idx;
  logic [LED_W-1:0]   gnt_pat;

  m_tick_gen #(
    .TICK_CNT (TICK_CNT)
  ) u_tick_gen (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .w_clr   (cnt_clr),
    .w_tick  (tick)
  );

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    grant_d  = grant_q;
    busy_d   = busy_q;
    led_d    = led_q;
    hb_d     = hb_q;
`ifdef LED_ARB_BLINK_EN
    ph_d     = ph_q;
`endif
    cnt_clr  = 1'b0;
    do_grant = 1'b0;
    slot_end = 1'b0;

    sel_oh  = rr_onehot(bus.w_req, ptr_q);
    sel_idx = onehot_to_idx(sel_oh);
    gnt_pat = bus.w_pat[{gidx_q, 2'b00} +: LED_W];

    case (state_q)
      IDLE: begin
        hb_d  = hb_q ^ tick;
        led_d = {LED_W{hb_d}};
        if (|bus.w_req) do_grant = 1'b1;
      end
      SHOW: begin
`ifdef LED_ARB_BLINK_EN
        led_d = gnt_pat & {LED_W{ph_q}};
        ph_d  = ph_q ^ tick;
`else
        led_d = gnt_pat;
`endif
        if (tick) slot_d = slot_q + SW'(1);
        // Early release counts as a slot end; its own bit is then clear so
        // the pick naturally moves on to someone else.
        slot_end = (tick && (slot_q == SW'(SLOT_TICKS - 1))) || !bus.w_req[gidx_q];
        if (slot_end) begin
          if (|bus.w_req) begin
            do_grant = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
            hb_d    = 1'b0;
            led_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Fresh slot: restart the tick phase so every slot is exactly
    // SLOT_TICKS*TICK_CNT cycles long.
    if (do_grant) begin
      state_d = SHOW;
      grant_d = sel_oh;
      gidx_d  = sel_idx;
      ptr_d   = sel_idx + PTR_W'(1);
      busy_d  = 1'b1;
      slot_d  = '0;
      cnt_clr = 1'b1;
`ifdef LED_ARB_BLINK_EN
      ph_d    = 1'b1;
`endif
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q <= IDLE;
      slot_q  <= '0;
      ptr_q   <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      led_q   <= '0;
      hb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
      hb_q    <= hb_d;
    end
  end

`ifdef LED_ARB_BLINK_EN
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) ph_q <= 1'b0;
    else          ph_q <= ph_d;
  end
`endif

  assign bus.w_led       = led_q;
  assign bus.w_grant     = grant_q;
  assign bus.w_busy      = busy_q;
  assign bus.w_dbg_state = state_q;

endmodule

// File: tb/tb_m_led_arbiter.sv
// Self-checking bench for m_led_arbiter with TICK_CNT=4, SLOT_TICKS=2.
// Reference model tracks cycles elapsed since the last grant and derives
// ticks, slot end, heartbeat and blink phase arithmetically from it.
module tb_m_led_arbiter;
  import led_arb_pkg::*;

  localparam int TICK  = 4;
  localparam int SLOTS = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  m_led_arbiter_if bus ();

  m_led_arbiter #(
    .TICK_CNT   (TICK),
    .SLOT_TICKS (SLOTS)
  ) dut (
    .w_clk   (clk),
    .w_rst_n (rst_n),
    .bus     (bus)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_busy;
  int         m_gidx;
  int         m_ptr;
  int         m_age;
  bit         m_hb;
  logic [3:0] m_grant;
  logic [3:0] m_led;

  function automatic int first_req(input logic [3:0] req, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (req[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_gidx  = 0;
    m_ptr   = 0;
    m_age   = 0;
    m_hb    = 0;
    m_grant = 4'b0000;
    m_led   = 4'b0000;
    exp_q.delete();
  endtask

  task automatic model_grant(input int sel);
    m_busy  = 1;
    m_gidx  = sel;
    m_grant = 4'b0001 << sel;
    m_ptr   = (sel + 1) % 4;
    m_age   = 0;
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic model_step(input logic [3:0] req, input logic [15:0] pat);
    bit         tick;
    bit         ph;
    int         sel;
    logic [3:0] cur_pat;
    tick    = (m_age % TICK) == TICK - 1;
    sel     = first_req(req, m_ptr);
    cur_pat = pat[m_gidx*4 +: 4];
    if (!m_busy) begin
      m_hb  = m_hb ^ tick;
      m_led = {4{m_hb}};
      if (sel >= 0) model_grant(sel);
      else          m_age++;
    end else begin
      ph = ((m_age / TICK) % 2) == 0;
`ifdef LED_ARB_BLINK_EN
      m_led = cur_pat & {4{ph}};
`else
      m_led = cur_pat;
`endif
      if (m_age == SLOTS * TICK - 1 || !req[m_gidx]) begin
        if (sel >= 0) model_grant(sel);
        else begin
          m_busy  = 0;
          m_grant = 4'b0000;
          m_hb    = 0;
          m_led   = 4'b0000;
          m_age++;
        end
      end else begin
        m_age++;
      end
    end
    exp_q.push_back(m_led);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] req, input logic [15:0] pat);
    bus.w_req = req;
    bus.w_pat = pat;
    model_step(req, pat);
  endtask

  // One cycle: compare what the last edge produced, then apply new inputs.
  task automatic step(input logic [3:0] req, input logic [15:0] pat);
    logic [3:0] exp_led;
    @(negedge clk);
    exp_led = (exp_q.size() > 0) ? exp_q.pop_front() : m_led;
    check_eq("led",   {12'h0, bus.w_led},   {12'h0, exp_led});
    check_eq("grant", {12'h0, bus.w_grant}, {12'h0, m_grant});
    check_eq("busy",  {15'h0, bus.w_busy},  {15'h0, m_busy});
    drive(req, pat);
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    bus.w_req = 4'b0000;
    bus.w_pat = 16'h0000;
    repeat (2) @(negedge clk);
    check_eq("rst_led",   {12'h0, bus.w_led},   16'h0);
    check_eq("rst_grant", {12'h0, bus.w_grant}, 16'h0);
    check_eq("rst_busy",  {15'h0, bus.w_busy},  16'h0);
    check_eq("rst_state", {15'h0, bus.w_dbg_state}, {15'h0, IDLE});
    rst_n = 1'b1;
    model_reset();
    drive(4'b0000, 16'h0000);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] pat_all;
  logic [3:0]  cur_req;
  logic [15:0] cur_pat;
  bit          dropped;
  int          wait_cnt;

  initial begin
    pat_all = 16'h8421 ^ 16'h5A00;

    // Idle heartbeat
    apply_reset();
    repeat (20) step(4'b0000, 16'h0000);

    // Single requester 2, pattern 1010, from a fresh reset
    apply_reset();
    step(4'b0100, 16'h0A00);
    @(posedge clk); #1;
    check_eq("single_grant", {12'h0, bus.w_grant}, 16'h0004);
    check_eq("single_busy",  {15'h0, bus.w_busy},  16'h0001);
    step(4'b0100, 16'h0A00);
    @(posedge clk); #1;
    check_eq("single_led", {12'h0, bus.w_led}, 16'h000A);
    repeat (28) step(4'b0100, 16'h0A00);

    // Everybody requesting, distinct patterns
    repeat (40) step(4'b1111, pat_all);

    // All requests dropped mid-slot, then idle heartbeat
    repeat (3) step(4'b1111, pat_all);
    step(4'b0000, pat_all);
    @(posedge clk); #1;
    check_eq("drop_busy", {15'h0, bus.w_busy}, 16'h0000);
    repeat (10) step(4'b0000, pat_all);

    // Early release of requester 1 while requester 3 waits
    cur_req  = 4'b1010;
    dropped  = 0;
    wait_cnt = 0;
    while (!dropped && wait_cnt < 60) begin
      if (m_busy && m_gidx == 1 && m_age == 2) begin
        cur_req = 4'b1000;
        dropped = 1;
      end
      step(cur_req, pat_all);
      wait_cnt++;
    end
    check_eq("early_rel_seen", {15'h0, dropped}, 16'h0001);
    @(posedge clk); #1;
    check_eq("early_rel_grant", {12'h0, bus.w_grant}, 16'h0008);
    repeat (12) step(cur_req, pat_all);

    // Asynchronous reset in the middle of a slot
    repeat (5) step(4'b0010, pat_all);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_led",   {12'h0, bus.w_led},   16'h0);
    check_eq("arst_grant", {12'h0, bus.w_grant}, 16'h0);
    check_eq("arst_busy",  {15'h0, bus.w_busy},  16'h0);
    apply_reset();
    step(4'b1111, pat_all);
    @(posedge clk); #1;
    check_eq("post_rst_grant", {12'h0, bus.w_grant}, 16'h0001);

    // Random traffic
    cur_req = 4'b0000;
    cur_pat = 16'h0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) cur_req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) cur_pat = 16'($urandom);
      step(cur_req, cur_pat);
    end
    step(4'b0000, cur_pat);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
